instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 29 ++
 rtl/instr_encoder_pack.sv | 62 ++++++
 rtl/instr_encoder.sv | 118 +++++++++++
 tb/tb_instr_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared constants and types for the instruction encoder slice:
//   opcode constants, the in_kind enumeration, immediate range limits and
//   the output state encoding.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    KIND_LOAD   = 2'd0,
    KIND_OP_IMM = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  // Legal range of a 12-bit signed immediate.
  localparam int signed IMM_MIN = -2048;
  localparam int signed IMM_MAX = 2047;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
//   Purely combinational packing of a field bundle into a 32-bit I-type or
//   S-type word, plus an error flag.
//   Configuration macro: IMM_RANGE_CHECK_EN -- when defined, immediates
//   outside [IMM_MIN, IMM_MAX] are flagged as errors; otherwise the
//   immediate is truncated to its low 12 bits.
// Ports:
//   kind_i        2  bundle kind (kind_e encoding)
//   rd_i/rs1_i/rs2_i 5 register fields
//   funct3_i      3  funct3 field
//   imm_i        32  signed immediate
//   instr_o      32  packed word (0 on error)
//   err_o         1  encoding error
// -----------------------------------------------------------------------------
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic        imm_in_range;
  logic        imm_ok;
  logic [11:0] imm12;

  assign imm_in_range = ($signed(imm_i) >= IMM_MIN) && ($signed(imm_i) <= IMM_MAX);
  // Without range checking every immediate is accepted and silently truncated.
  assign imm_ok       = !RANGE_CHECK || imm_in_range;
  assign imm12        = imm_i[11:0];

  always_comb begin
    instr_o = 32'h0000_0000;
    err_o   = 1'b0;
    case (kind_e'(kind_i))
      KIND_LOAD:   instr_o = {imm12, rs1_i, funct3_i, rd_i, OPC_LOAD};
      KIND_OP_IMM: instr_o = {imm12, rs1_i, funct3_i, rd_i, OPC_OP_IMM};
      KIND_STORE:  instr_o = {imm12[11:5], rs2_i, rs1_i, funct3_i, imm12[4:0], OPC_STORE};
      default:     err_o   = 1'b1;
    endcase
    if (!imm_ok) begin
      err_o = 1'b1;
    end
    // An error word always carries an all-zero instruction.
    if (err_o) begin
      instr_o = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Accepts field bundles, encodes them (via instr_pack) into a one-deep
//   output register with latency 1, tags each word with a byte address and
//   counts error-free words transferred.
//   Configuration macro: IMM_RANGE_CHECK_EN (see instr_pack).
// Handshake: a transfer happens on any cycle where valid && ready on that
//   side; valid never depends on ready, in_ready = !out_valid || out_ready
//   (forced low during clear and reset) so the register refills in the same
//   cycle it drains.
// Ports:
//   clk, rst_n (async active-low), clear (sync restart)
//   in_valid/in_ready, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm
//   out_valid/out_ready, out_instr, out_addr, out_err, out_count
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] out_count
);

  logic [31:0] pack_instr;
  logic        pack_err;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q,   err_d;
  logic [31:0] addr_q,  addr_d;
  logic [15:0] count_q, count_d;

  logic in_xfer;
  logic out_xfer;

  instr_pack u_pack (
    .kind_i   (in_kind),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .imm_i    (in_imm),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = rst_n && !clear && (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready && !clear;

  // addr_q is the address of the word currently held while FULL, and the
  // address the next loaded word will get while EMPTY.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    count_d = count_q;
    if (clear) begin
      state_d = ST_EMPTY;
      addr_d  = BASE_ADDR;
      count_d = 16'h0000;
    end else begin
      if (out_xfer) begin
        addr_d = addr_q + 32'd4;
        if (!err_q && (count_q != 16'hFFFF)) begin
          count_d = count_q + 16'd1;
        end
      end
      if (in_xfer) begin
        state_d = ST_FULL;
        instr_d = pack_instr;
        err_d   = pack_err;
      end else if (out_xfer) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      instr_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_addr  = addr_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFFC;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] out_count;

  int checks = 0;
  int errors = 0;

  // {err, addr, instr}
  logic [64:0] exp_q[$];
  logic [31:0] next_addr;
  bit          sender_done;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .out_count (out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
    int budget;
    in_valid  = 1'b1;
    in_kind   = kind;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
    budget    = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: act=in_ready=0 req=in_ready=1");
    end else begin
      exp_q.push_back({exp_err, next_addr, exp_instr});
      next_addr = next_addr + 32'd4;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: act=%0d pending req=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: act=%h@%h req=none", out_instr, out_addr);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("out_instr", out_instr, e[31:0]);
        check("out_addr", out_addr, e[63:32]);
        check("out_err", {31'd0, out_err}, {31'd0, e[64]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int xfers;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = 2'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0; in_imm = 32'd0;
    next_addr = BASE;
    sender_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_count", {16'd0, out_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // basic encodings, ignored fields carry junk; addresses wrap FFFFFFFC -> 0 -> 4
    send(2'd0, 5'd5, 5'd2, 5'd31, 3'd2, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
    send(2'd2, 5'd31, 5'd1, 5'd3, 3'd2, 32'h0000_0008, 32'h0030_A423, 1'b0);
    send(2'd1, 5'd1, 5'd0, 5'd17, 3'd0, 32'h0000_07FF, 32'h7FF0_0093, 1'b0);
    drain();
    check("count_after_3", {16'd0, out_count}, 32'd3);

    // immediate boundaries and reserved kind
    send(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, RC ? 32'h0 : 32'h8000_0093, RC);
    send(2'd3, 5'd7, 5'd7, 5'd7, 3'd7, 32'h0000_0001, 32'h0000_0000, 1'b1);
    send(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F7FF, RC ? 32'h0 : 32'h7FF0_0093, RC);
    send(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    drain();
    check("count_after_imm", {16'd0, out_count}, RC ? 32'd4 : 32'd6);

    // stall for 5 cycles, then release into back-to-back traffic
    out_ready = 1'b0;
    fork
      begin
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd2, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
        send(2'd2, 5'd0, 5'd1, 5'd3, 3'd2, 32'h0000_0008, 32'h0030_A423, 1'b0);
        send(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_07FF, 32'h7FF0_0093, 1'b0);
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd2, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
        sender_done = 1'b1;
      end
    join_none
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      if (exp_q.size() != 0) begin
        check("stall_instr", out_instr, exp_q[0][31:0]);
        check("stall_addr", out_addr, exp_q[0][63:32]);
      end else begin
        checks++;
        errors++;
        $display("FAIL stall_pending: act=0 words req=1");
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
    end
    check("back_to_back", xfers, 32'd4);
    begin
      int budget;
      budget = 0;
      while (!sender_done && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      check("sender_done", {31'd0, sender_done}, 32'd1);
    end
    drain();
    check("count_after_stall", {16'd0, out_count}, RC ? 32'd8 : 32'd10);

    // clear while FULL, with an output and an input both offered
    out_ready = 1'b0;
    send(2'd0, 5'd5, 5'd2, 5'd0, 3'd2, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
    exp_q.delete();
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    next_addr = BASE;
    @(negedge clk);
    check("clear_out_valid", {31'd0, out_valid}, 32'd0);
    check("clear_out_count", {16'd0, out_count}, 32'd0);
    check("clear_out_addr", out_addr, BASE);
    send(2'd2, 5'd0, 5'd1, 5'd3, 3'd2, 32'h0000_0008, 32'h0030_A423, 1'b0);
    drain();
    check("count_after_clear", {16'd0, out_count}, 32'd1);

    // asynchronous reset while FULL
    out_ready = 1'b0;
    send(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_07FF, 32'h7FF0_0093, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    next_addr = BASE;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    check("arst_out_addr", out_addr, BASE);
    check("arst_out_count", {16'd0, out_count}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 32'h0000_0000, 1'b1);
    send(2'd0, 5'd5, 5'd2, 5'd0, 3'd2, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
    drain();
    check("count_after_reset", {16'd0, out_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
